// File: rtl/song_reader.sv
// Note sequencer: walks a song ROM, hands each note to the player and waits for note_done.
// Optional build macro SONG_READER_LOOP_EN makes a finished song restart while play is held.
module song_reader #(
  parameter int SONG_BITS      = 2,
  parameter int NOTE_ADDR_BITS = 5,
  parameter int NOTE_WIDTH     = 6,
  parameter int DUR_WIDTH      = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                play,
  input  logic [SONG_BITS-1:0]                song,
  input  logic                                note_done,
  output logic [SONG_BITS+NOTE_ADDR_BITS-1:0] rom_addr,
  input  logic [NOTE_WIDTH+DUR_WIDTH-1:0]     rom_data,
  output logic [NOTE_WIDTH-1:0]               note,
  output logic [DUR_WIDTH-1:0]                duration,
  output logic                                new_note,
  output logic                                song_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_ADVANCE   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [SONG_BITS-1:0]        r_song_q;
  logic [NOTE_ADDR_BITS-1:0]   r_note_idx;
  logic [NOTE_WIDTH-1:0]       r_note;
  logic [DUR_WIDTH-1:0]        r_duration;
  logic                        r_new_note;
  logic                        r_song_done;

  logic                        w_active;
  logic                        w_abort;
  logic                        w_latch_song;
  logic                        w_clear_idx;
  logic                        w_inc_idx;
  logic                        w_load;
  logic [NOTE_WIDTH-1:0]       w_note_field;
  logic [DUR_WIDTH-1:0]        w_dur_field;

  assign w_note_field = rom_data[NOTE_WIDTH+DUR_WIDTH-1:DUR_WIDTH];
  assign w_dur_field  = rom_data[DUR_WIDTH-1:0];

  // A song change only aborts while a song is actually being walked.
  assign w_active = (r_state == S_FETCH) || (r_state == S_WAIT_ROM) || (r_state == S_ISSUE) ||
                    (r_state == S_WAIT_DONE) || (r_state == S_ADVANCE);
  assign w_abort  = play && (song != r_song_q) && w_active;

  // Next-state and datapath control; play=0 holds every state except IDLE, WAIT_DONE and DONE.
  always_comb begin
    w_next       = r_state;
    w_latch_song = 1'b0;
    w_clear_idx  = 1'b0;
    w_inc_idx    = 1'b0;
    w_load       = 1'b0;
    if (w_abort) begin
      w_next       = S_FETCH;
      w_latch_song = 1'b1;
      w_clear_idx  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (play) begin
            w_next       = S_FETCH;
            w_latch_song = 1'b1;
            w_clear_idx  = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_FETCH: begin
          if (play) w_next = S_WAIT_ROM;
          else      w_next = S_FETCH;
        end
        S_WAIT_ROM: begin
          if (!play) begin
            w_next = S_WAIT_ROM;
          end else if (w_dur_field == {DUR_WIDTH{1'b0}}) begin
            w_next = S_DONE;
          end else begin
            w_next = S_ISSUE;
            w_load = 1'b1;
          end
        end
        S_ISSUE: begin
          if (play) w_next = S_WAIT_DONE;
          else      w_next = S_ISSUE;
        end
        S_WAIT_DONE: begin
          if (!note_done)       w_next = S_WAIT_DONE;
          else if (&r_note_idx) w_next = S_DONE;
          else                  w_next = S_ADVANCE;
        end
        S_ADVANCE: begin
          if (play) begin
            w_next    = S_FETCH;
            w_inc_idx = 1'b1;
          end else begin
            w_next = S_ADVANCE;
          end
        end
        S_DONE: begin
          // DONE is a single-cycle state so song_done is always exactly one pulse.
          w_clear_idx = 1'b1;
`ifdef SONG_READER_LOOP_EN
          if (play) w_next = S_FETCH;
          else      w_next = S_IDLE;
`else
          w_next = S_IDLE;
`endif
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // State, song/index registers, note latch and the two output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_song_q    <= {SONG_BITS{1'b0}};
      r_note_idx  <= {NOTE_ADDR_BITS{1'b0}};
      r_note      <= {NOTE_WIDTH{1'b0}};
      r_duration  <= {DUR_WIDTH{1'b0}};
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch_song) r_song_q <= song;
      if (w_clear_idx)    r_note_idx <= {NOTE_ADDR_BITS{1'b0}};
      else if (w_inc_idx) r_note_idx <= r_note_idx + NOTE_ADDR_BITS'(1);
      if (w_load) begin
        r_note     <= w_note_field;
        r_duration <= w_dur_field;
      end
      // Pulses fire on entry only, so a pause while in ISSUE cannot repeat new_note.
      r_new_note  <= (w_next == S_ISSUE) && (r_state != S_ISSUE);
      r_song_done <= (w_next == S_DONE) && (r_state != S_DONE);
    end
  end

  assign rom_addr  = {r_song_q, r_note_idx};
  assign note      = r_note;
  assign duration  = r_duration;
  assign new_note  = r_new_note;
  assign song_done = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: ROM model, player handshake and a scoreboard of expected notes.
module tb_song_reader;

  typedef struct packed {
    logic [6:0] addr;
    logic [5:0] nt;
    logic [5:0] dur;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] rom [128];
  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          nn_count = 0;
  int          sd_count = 0;

  song_reader dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .duration(duration),
    .new_note(new_note), .song_done(song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int a, input int n, input int d);
    exp_t e;
    e.addr = 7'(a);
    e.nt   = 6'(n);
    e.dur  = 6'(d);
    return e;
  endfunction

  // sel=0 waits for new_note, sel=1 for song_done; n = negedges waited (budget on timeout)
  task automatic wait_sig(input bit sel, input int budget, output int n);
    n = 0;
    while (((sel ? song_done : new_note) !== 1'b1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic give_done();
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
  endtask

  // scoreboard: every new_note pops the next expected entry
  always @(negedge clk) begin
    if (new_note === 1'b1) begin
      nn_count++;
      if (q.size() == 0) begin
        chk("nn_unexpected", 32'(rom_addr), 32'h7f);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("nn_note", 32'(note), 32'(e.nt));
        chk("nn_dur",  32'(duration), 32'(e.dur));
        chk("nn_addr", 32'(rom_addr), 32'(e.addr));
      end
    end
    if (song_done === 1'b1) sd_count++;
    if ((new_note === 1'b1) || (song_done === 1'b1))
      chk("nn_sd_exclusive", 32'(new_note & song_done), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nn0;
    int sd0;
    for (int i = 0; i < 128; i++) rom[i] = 12'h000;
    rom[0] = {6'd5, 6'd3};
    rom[1] = {6'd7, 6'd2};
    for (int k = 0; k < 32; k++) rom[32+k] = {6'(k+1), 6'((k % 7) + 1)};
    rom[64] = {6'd9, 6'd4};
    rom[65] = {6'd11, 6'd5};

    reset = 1'b1; play = 1'b0; song = 2'd0; note_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_dur", 32'(duration), 32'd0);
    chk("rst_new_note", 32'(new_note), 32'd0);
    chk("rst_song_done", 32'(song_done), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    repeat (5) @(negedge clk);

    // basic two-note song
    q.push_back(mk(0, 5, 3));
    q.push_back(mk(1, 7, 2));
    play = 1'b1;
    wait_sig(1'b0, 10, n); chk("basic_latency", 32'(n), 32'd3);
    @(negedge clk); give_done();
    wait_sig(1'b0, 10, n); chk("basic_gap", 32'(n), 32'd3);
    @(negedge clk); nn0 = nn_count; give_done();
    wait_sig(1'b1, 10, n); chk("basic_end_latency", 32'(n), 32'd3);
    chk("basic_no_third", 32'(nn_count), 32'(nn0));
    play = 1'b0;
    @(negedge clk); chk("basic_idle_addr", 32'(rom_addr), 32'd0);

    // full 32-entry song 1
    song = 2'd1;
    for (int k = 0; k < 32; k++) q.push_back(mk(32 + k, k + 1, (k % 7) + 1));
    nn0 = nn_count; sd0 = sd_count;
    play = 1'b1;
    for (int k = 0; k < 32; k++) begin
      wait_sig(1'b0, 10, n); chk("full_latency", 32'(n), 32'd3);
      @(negedge clk); give_done();
    end
    wait_sig(1'b1, 10, n); chk("full_end_latency", 32'(n), 32'd0);
    play = 1'b0;
    @(negedge clk);
    chk("full_nn_count", 32'(nn_count - nn0), 32'd32);
    chk("full_sd_count", 32'(sd_count - sd0), 32'd1);
    chk("full_idx_cleared", 32'(rom_addr), 32'd32);

    // pause in FETCH
    song = 2'd0;
    q.push_back(mk(0, 5, 3));
    play = 1'b1;
    @(negedge clk); play = 1'b0; nn0 = nn_count;
    repeat (20) @(negedge clk);
    chk("pause_fetch_quiet", 32'(nn_count), 32'(nn0));
    chk("pause_fetch_addr", 32'(rom_addr), 32'd0);
    play = 1'b1;
    wait_sig(1'b0, 10, n); chk("pause_fetch_resume", 32'(n), 32'd2);

    // pause in WAIT_DONE: note_done still advances, block holds in ADVANCE
    @(negedge clk); play = 1'b0;
    q.push_back(mk(1, 7, 2));
    give_done(); nn0 = nn_count;
    repeat (5) @(negedge clk);
    chk("pause_wd_quiet", 32'(nn_count), 32'(nn0));
    chk("pause_wd_addr", 32'(rom_addr), 32'd0);
    play = 1'b1;
    wait_sig(1'b0, 10, n); chk("pause_wd_resume", 32'(n), 32'd3);
    @(negedge clk); give_done();
    wait_sig(1'b1, 10, n); chk("pause_end_latency", 32'(n), 32'd3);
    play = 1'b0;
    @(negedge clk);

    // song change 0 -> 2 while waiting on note 3
    for (int k = 0; k < 5; k++) rom[k] = {6'(k + 10), 6'(k + 1)};
    rom[5] = 12'h000;
    for (int k = 0; k < 4; k++) q.push_back(mk(k, k + 10, k + 1));
    play = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_sig(1'b0, 10, n); chk("chg_latency", 32'(n), 32'd3);
      @(negedge clk);
      if (k < 3) give_done();
    end
    sd0 = sd_count;
    song = 2'd2;
    @(negedge clk); chk("chg_addr", 32'(rom_addr), 32'd64);
    q.push_back(mk(64, 9, 4));
    give_done();
    wait_sig(1'b0, 10, n); chk("chg_new_note_latency", 32'(n), 32'd1);
    chk("chg_no_song_done", 32'(sd_count), 32'(sd0));

    // reset in WAIT_DONE
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rstm_note", 32'(note), 32'd0);
    chk("rstm_dur", 32'(duration), 32'd0);
    chk("rstm_new_note", 32'(new_note), 32'd0);
    chk("rstm_song_done", 32'(song_done), 32'd0);
    chk("rstm_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk); chk("rstm_restart_addr", 32'(rom_addr), 32'd64);
    q.push_back(mk(64, 9, 4));
    wait_sig(1'b0, 10, n); chk("rstm_latency", 32'(n), 32'd2);
    @(negedge clk); q.push_back(mk(65, 11, 5)); give_done();
    wait_sig(1'b0, 10, n); chk("s2_gap", 32'(n), 32'd3);
    @(negedge clk); give_done();
    wait_sig(1'b1, 10, n); chk("s2_end_latency", 32'(n), 32'd3);

`ifdef SONG_READER_LOOP_EN
    q.push_back(mk(64, 9, 4));
    wait_sig(1'b0, 10, n); chk("loop_restart", 32'(n), 32'd3);
    play = 1'b0;
`else
    play = 1'b0; nn0 = nn_count;
    repeat (10) @(negedge clk);
    chk("noloop_quiet", 32'(nn_count), 32'(nn0));
    chk("noloop_idle_addr", 32'(rom_addr), 32'd64);
    q.push_back(mk(64, 9, 4));
    play = 1'b1;
    wait_sig(1'b0, 10, n); chk("noloop_resample", 32'(n), 32'd3);
    play = 1'b0;
`endif
    @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
